rv_branch_ctrl: RTL and testbench
=================================

RV_BRANCH_CTRL -- requirements
Module: rv_branch_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the saturating performance counters.
REQ-002 clk  in  1  single core clock; all state on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 br_valid  in  1  branch request from decode.
REQ-005 br_ready  out  1  request accepted when br_valid && br_ready.
REQ-006 br_type  in  3  RV32I branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-007 br_pc, br_imm, br_rs1, br_rs2  in  32 each  branch PC, sign-extended offset, operands.
REQ-008 br_pred_taken  in  1  fetch-stage prediction for this branch.
REQ-009 flush_i  in  1  pipeline kill, higher priority than everything.
REQ-010 alu_req  out  1  request for the shared ALU adder/comparator.
REQ-011 alu_gnt  in  1  grant from the ALU arbiter; comparator result valid in the same cycle.
REQ-012 alu_op_a, alu_op_b  out  32  operands (rs1, rs2); alu_sub out 1 (1 = subtract).
REQ-013 cmp_en out 1, cmp_sign out 1, cmp_op out comp_op_e: comparator controls; cmp_res in 1: comparator result.
REQ-014 resolve_valid out 1, resolve_taken out 1: one-cycle resolution pulse for predictor update.
REQ-015 redirect_valid out 1, redirect_pc out 32, redirect_ready in 1: fetch redirect handshake.
REQ-016 perf_branch_cnt, perf_mispred_cnt  out  CNT_W  resolved-branch and mispredict counts.

Function
REQ-017 States: IDLE, REQ, DONE, REDIR; br_ready = (state==IDLE) && !flush_i.
REQ-018 On accept, pc, imm, rs1, rs2, type, pred are registered; next state REQ, or DONE with taken=0 if type is 010/011 (no ALU request).
REQ-019 In REQ: alu_req=1, alu_sub=1, cmp_en=1, alu_op_a=rs1_q, alu_op_b=rs2_q; outside REQ all four are 0 and operands are 0.
REQ-020 Mapping: BEQ ALU_EQ; BNE ALU_NE; BLT ALU_LT sign=1; BGE ALU_GE sign=1; BLTU ALU_LT sign=0; BGEU ALU_GE sign=0.
REQ-021 REQ holds all outputs stable until alu_gnt; on alu_gnt, taken_q<=cmp_res and state->DONE.
REQ-022 Target = pc_q+imm_q, fallthrough = pc_q+4, both modulo 2^32 (wrap, no overflow flag).
REQ-023 DONE lasts exactly one cycle: resolve_valid=1, resolve_taken=taken_q; perf_branch_cnt increments.
REQ-024 Mispredict = taken_q != pred_q; in DONE, a mispredict increments perf_mispred_cnt and moves to REDIR, otherwise to IDLE.
REQ-025 In REDIR: redirect_valid=1, redirect_pc = taken_q ? target : fallthrough, held stable until redirect_ready; then IDLE.
REQ-026 Best-case latency: accept at T, grant at T+1, resolve at T+2, redirect_valid from T+3.
REQ-027 Counters saturate at all-ones and do not wrap.
REQ-028 flush_i in any state: next state IDLE; no resolve pulse, no redirect, no counter update.
REQ-029 flush_i in the same cycle as alu_gnt or redirect_ready: the flush wins and the result is discarded.
REQ-030 br_ready is low outside IDLE, so only one branch is in flight; back-to-back accept is allowed in the cycle after return to IDLE.

Reset
REQ-031 While rst_n=0: state IDLE, all output valids/requests 0, taken_q 0, counters 0, redirect_pc 0, registered operands 0.
REQ-032 Reset mid-operation abandons the in-flight branch with no further output activity.

Verification
REQ-033 BEQ rs1=5 rs2=5 pc=0x100 imm=0x20 pred=0, gnt at once -> cmp_op ALU_EQ, resolve_taken=1 at T+2, redirect_pc=0x120 at T+3, mispred_cnt=1.
REQ-034 BLTU rs1=0xFFFFFFFF rs2=1 pred=0 -> cmp_sign=0, not taken, no redirect, branch_cnt=1, mispred_cnt=0.
REQ-035 BGE rs1=0x80000000 rs2=1 pc=0xFFFFFFF0 imm=0x20 pred=1 -> not taken, redirect_pc=0xFFFFFFF4; separately BGEU, same operands, taken -> target wraps to 0x00000010.
REQ-036 alu_gnt withheld 5 cycles, then redirect_ready withheld 3 cycles -> alu_req and operands stable; redirect_valid/pc stable for 4 cycles; one resolve pulse only.
REQ-037 flush_i asserted in the REDIR cycle, and separately in the alu_gnt cycle -> IDLE next cycle, no redirect, counters unchanged.
REQ-038 Saturation: preload 0xFFFF resolves -> perf_branch_cnt stays 0xFFFF; reset asserted in REQ -> alu_req falls asynchronously and counters clear.

Source files
------------

// File: rtl/rv_branch_ctrl_if.sv
// Branch controller bus: decode request, shared ALU/comparator, resolution,
// fetch redirect and performance counters, plus the comparator op type.
package rv_branch_ctrl_pkg;
    typedef enum logic [1:0] {
        ALU_EQ = 2'd0,
        ALU_NE = 2'd1,
        ALU_LT = 2'd2,
        ALU_GE = 2'd3
    } comp_op_e;
endpackage

interface rv_branch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import rv_branch_ctrl_pkg::*;

    logic              br_valid;
    logic              br_ready;
    logic [2:0]        br_type;
    logic [31:0]       br_pc;
    logic [31:0]       br_imm;
    logic [31:0]       br_rs1;
    logic [31:0]       br_rs2;
    logic              br_pred_taken;
    logic              flush_i;
    logic              alu_req;
    logic              alu_gnt;
    logic [31:0]       alu_op_a;
    logic [31:0]       alu_op_b;
    logic              alu_sub;
    logic              cmp_en;
    logic              cmp_sign;
    comp_op_e          cmp_op;
    logic              cmp_res;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              redirect_ready;
    logic [CNT_W-1:0]  perf_branch_cnt;
    logic [CNT_W-1:0]  perf_mispred_cnt;

    // Controller side
    modport slave (
        input  br_valid, br_type, br_pc, br_imm, br_rs1, br_rs2, br_pred_taken,
        input  flush_i, alu_gnt, cmp_res, redirect_ready,
        output br_ready, alu_req, alu_op_a, alu_op_b, alu_sub,
        output cmp_en, cmp_sign, cmp_op, resolve_valid, resolve_taken,
        output redirect_valid, redirect_pc, perf_branch_cnt, perf_mispred_cnt
    );

    // Decode / ALU / fetch side
    modport master (
        output br_valid, br_type, br_pc, br_imm, br_rs1, br_rs2, br_pred_taken,
        output flush_i, alu_gnt, cmp_res, redirect_ready,
        input  br_ready, alu_req, alu_op_a, alu_op_b, alu_sub,
        input  cmp_en, cmp_sign, cmp_op, resolve_valid, resolve_taken,
        input  redirect_valid, redirect_pc, perf_branch_cnt, perf_mispred_cnt
    );
endinterface

// File: rtl/rv_branch_ctrl.sv
// RV32I branch resolution controller: borrows the shared comparator, pulses a
// predictor update, redirects fetch on mispredict and counts branches.
module rv_branch_ctrl
    import rv_branch_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    rv_branch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_REDIR} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [2:0]       type_q, type_d;
    logic             pred_q, pred_d, taken_q, taken_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign accept = bus.br_valid && (state_q == S_IDLE) && !bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            type_q        <= '0;
            pred_q        <= 1'b0;
            taken_q       <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            type_q        <= type_d;
            pred_q        <= pred_d;
            taken_q       <= taken_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        type_d        = type_q;
        pred_d        = pred_q;
        taken_d       = taken_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        // Flush overrides grant, resolve and redirect: nothing is committed.
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        pc_d    = bus.br_pc;
                        imm_d   = bus.br_imm;
                        rs1_d   = bus.br_rs1;
                        rs2_d   = bus.br_rs2;
                        type_d  = bus.br_type;
                        pred_d  = bus.br_pred_taken;
                        taken_d = 1'b0;
                        // funct3 010/011 are not branches: resolve not-taken without the ALU.
                        state_d = (bus.br_type[2:1] == 2'b01) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.alu_gnt) begin
                        taken_d = bus.cmp_res;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    branch_cnt_d = sat_inc(branch_cnt_q);
                    if (taken_q != pred_q) begin
                        mispred_cnt_d = sat_inc(mispred_cnt_q);
                        state_d       = S_REDIR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_REDIR: begin
                    if (bus.redirect_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.br_ready       = (state_q == S_IDLE) && !bus.flush_i;
        bus.alu_req        = 1'b0;
        bus.alu_sub        = 1'b0;
        bus.cmp_en         = 1'b0;
        bus.alu_op_a       = '0;
        bus.alu_op_b       = '0;
        bus.cmp_op         = ALU_EQ;
        bus.cmp_sign       = 1'b0;
        bus.resolve_valid  = (state_q == S_DONE) && !bus.flush_i;
        bus.resolve_taken  = taken_q;
        bus.redirect_valid = (state_q == S_REDIR) && !bus.flush_i;
        bus.redirect_pc    = '0;
        case (type_q)
            3'b001:  bus.cmp_op = ALU_NE;
            3'b100:  begin bus.cmp_op = ALU_LT; bus.cmp_sign = 1'b1; end
            3'b101:  begin bus.cmp_op = ALU_GE; bus.cmp_sign = 1'b1; end
            3'b110:  bus.cmp_op = ALU_LT;
            3'b111:  bus.cmp_op = ALU_GE;
            default: bus.cmp_op = ALU_EQ;
        endcase
        if (state_q == S_REQ) begin
            bus.alu_req  = 1'b1;
            bus.alu_sub  = 1'b1;
            bus.cmp_en   = 1'b1;
            bus.alu_op_a = rs1_q;
            bus.alu_op_b = rs2_q;
        end
        if (state_q == S_REDIR) begin
            bus.redirect_pc = taken_q ? (pc_q + imm_q) : (pc_q + 32'd4);
        end
    end

    assign bus.perf_branch_cnt  = branch_cnt_q;
    assign bus.perf_mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_rv_branch_ctrl.sv
// Directed and random checks of rv_branch_ctrl against a branch-semantics
// reference model; the bench also plays the shared comparator.
module tb_rv_branch_ctrl;
    import rv_branch_ctrl_pkg::*;

    localparam int unsigned CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   m_br;
    int   m_mp;

    rv_branch_ctrl_if #(.CNT_W(CW)) bus ();

    rv_branch_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Comparator behaviour as seen by the controller
    always_comb begin
        case (bus.cmp_op)
            ALU_EQ:  bus.cmp_res = (bus.alu_op_a == bus.alu_op_b);
            ALU_NE:  bus.cmp_res = (bus.alu_op_a != bus.alu_op_b);
            ALU_LT:  bus.cmp_res = bus.cmp_sign ? ($signed(bus.alu_op_a) < $signed(bus.alu_op_b))
                                                : (bus.alu_op_a < bus.alu_op_b);
            ALU_GE:  bus.cmp_res = bus.cmp_sign ? ($signed(bus.alu_op_a) >= $signed(bus.alu_op_b))
                                                : (bus.alu_op_a >= bus.alu_op_b);
            default: bus.cmp_res = 1'b0;
        endcase
    end

    function automatic logic ref_taken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        case (t)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic comp_op_e ref_op(input logic [2:0] t);
        case (t)
            3'b001:        return ALU_NE;
            3'b100, 3'b110: return ALU_LT;
            3'b101, 3'b111: return ALU_GE;
            default:       return ALU_EQ;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_branch_cnt"}, 32'(bus.perf_branch_cnt), 32'(m_br));
        chk({tag, "_mispred_cnt"}, 32'(bus.perf_mispred_cnt), 32'(m_mp));
    endtask

    // fmode: 0 none, 1 flush in the grant cycle, 2 flush in the redirect-ready cycle
    task automatic run_branch(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] rs1, input logic [31:0] rs2, input logic pred,
                              input int gnt_wait, input int rdy_wait, input int fmode);
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic        no_alu;
        logic        fl;
        no_alu    = (t == 3'b010) || (t == 3'b011);
        exp_taken = ref_taken(t, rs1, rs2);
        exp_pc    = exp_taken ? pc + imm : pc + 32'd4;

        @(negedge clk);
        bus.br_valid = 1'b1;
        bus.br_type = t; bus.br_pc = pc; bus.br_imm = imm;
        bus.br_rs1 = rs1; bus.br_rs2 = rs2; bus.br_pred_taken = pred;
        #1;
        chk("br_ready_idle", 32'(bus.br_ready), 32'd1);
        if (bus.br_ready !== 1'b1) begin
            bus.br_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.br_valid = 1'b0;

        if (!no_alu) begin
            for (int k = 0; k <= gnt_wait; k++) begin
                bus.alu_gnt = (k == gnt_wait);
                bus.flush_i = (fmode == 1) && (k == gnt_wait);
                #1;
                chk("alu_req",   32'(bus.alu_req),  32'd1);
                chk("alu_sub",   32'(bus.alu_sub),  32'd1);
                chk("cmp_en",    32'(bus.cmp_en),   32'd1);
                chk("alu_op_a",  bus.alu_op_a,      rs1);
                chk("alu_op_b",  bus.alu_op_b,      rs2);
                chk("cmp_op",    32'(bus.cmp_op),   32'(ref_op(t)));
                chk("cmp_sign",  32'(bus.cmp_sign), 32'(t == 3'b100 || t == 3'b101));
                chk("br_ready_busy", 32'(bus.br_ready), 32'd0);
                chk("resolve_in_req", 32'(bus.resolve_valid), 32'd0);
                @(negedge clk);
            end
            bus.alu_gnt = 1'b0;
            bus.flush_i = 1'b0;
            if (fmode == 1) begin
                #1;
                chk("flush_gnt_idle", 32'(bus.br_ready), 32'd1);
                chk("flush_gnt_no_resolve", 32'(bus.resolve_valid), 32'd0);
                chk("flush_gnt_alu_req", 32'(bus.alu_req), 32'd0);
                chk_cnts("flush_gnt");
                return;
            end
        end

        #1;
        chk("resolve_valid", 32'(bus.resolve_valid), 32'd1);
        chk("resolve_taken", 32'(bus.resolve_taken), 32'(exp_taken));
        chk("alu_req_done", 32'(bus.alu_req), 32'd0);
        chk("redirect_in_done", 32'(bus.redirect_valid), 32'd0);
        m_br = (m_br < CMAX) ? m_br + 1 : m_br;
        if (exp_taken != pred) m_mp = (m_mp < CMAX) ? m_mp + 1 : m_mp;
        @(negedge clk);
        #1;
        chk_cnts("after_done");

        if (exp_taken != pred) begin
            for (int k = 0; k <= rdy_wait; k++) begin
                fl = (fmode == 2) && (k == rdy_wait);
                bus.redirect_ready = (k == rdy_wait);
                bus.flush_i = fl;
                #1;
                chk("redirect_valid", 32'(bus.redirect_valid), 32'(!fl));
                if (!fl) chk("redirect_pc", bus.redirect_pc, exp_pc);
                chk("resolve_in_redir", 32'(bus.resolve_valid), 32'd0);
                @(negedge clk);
            end
            bus.redirect_ready = 1'b0;
            bus.flush_i = 1'b0;
            #1;
        end
        chk("end_idle", 32'(bus.br_ready), 32'd1);
        chk("end_no_redirect", 32'(bus.redirect_valid), 32'd0);
        chk("end_no_resolve", 32'(bus.resolve_valid), 32'd0);
        chk_cnts("end");
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_alu_req"},  32'(bus.alu_req), 32'd0);
        chk({tag, "_op_a"},     bus.alu_op_a, 32'd0);
        chk({tag, "_resolve"},  32'(bus.resolve_valid), 32'd0);
        chk({tag, "_redirect"}, 32'(bus.redirect_valid), 32'd0);
        chk({tag, "_redir_pc"}, bus.redirect_pc, 32'd0);
        chk_cnts(tag);
    endtask

    initial begin
        checks = 0; errors = 0; m_br = 0; m_mp = 0;
        rst_n = 1'b0;
        bus.br_valid = 1'b0; bus.br_type = '0; bus.br_pc = '0; bus.br_imm = '0;
        bus.br_rs1 = '0; bus.br_rs2 = '0; bus.br_pred_taken = 1'b0;
        bus.flush_i = 1'b0; bus.alu_gnt = 1'b0; bus.redirect_ready = 1'b0;
        #1;
        reset_checks("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // BEQ equal, mispredicted not-taken
        run_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 0, 0, 0);
        chk("beq_mispred_cnt", 32'(bus.perf_mispred_cnt), 32'd1);
        // BLTU unsigned compare, correct prediction
        run_branch(3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, 0);
        // BGE signed not-taken near top of address space; BGEU taken target wraps
        run_branch(3'b101, 32'hFFFF_FFF0, 32'h20, 32'h8000_0000, 32'd1, 1'b1, 0, 0, 0);
        run_branch(3'b111, 32'hFFFF_FFF0, 32'h20, 32'h8000_0000, 32'd1, 1'b0, 0, 0, 0);
        // Stalled grant and stalled redirect
        run_branch(3'b001, 32'h400, 32'hFFFF_FFF8, 32'd1, 32'd2, 1'b0, 5, 3, 0);
        // Flush in redirect cycle, then in grant cycle
        run_branch(3'b100, 32'h500, 32'h10, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 2, 2);
        run_branch(3'b000, 32'h600, 32'h10, 32'd7, 32'd7, 1'b0, 2, 0, 1);
        // Non-branch funct3 resolves not-taken without the ALU
        run_branch(3'b011, 32'h700, 32'h10, 32'd1, 32'd1, 1'b1, 0, 0, 0);

        // Reset in REQ abandons the branch asynchronously
        @(negedge clk);
        bus.br_valid = 1'b1; bus.br_type = 3'b000; bus.br_rs1 = 32'd3; bus.br_rs2 = 32'd3;
        bus.br_pred_taken = 1'b0;
        @(negedge clk);
        bus.br_valid = 1'b0;
        #1;
        chk("pre_reset_alu_req", 32'(bus.alu_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        m_br = 0; m_mp = 0;
        reset_checks("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of both counters
        for (int i = 0; i < CMAX + 5; i++)
            run_branch(3'b010, 32'(i * 4), 32'h8, 32'd0, 32'd0, 1'b1, 0, 0, 0);
        chk("sat_branch", 32'(bus.perf_branch_cnt), 32'(CMAX));
        chk("sat_mispred", 32'(bus.perf_mispred_cnt), 32'(CMAX));

        // Random branches
        rst_n = 1'b0;
        #1;
        m_br = 0; m_mp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  t;
            logic [31:0] a;
            logic [31:0] b;
            t = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_branch(t, $urandom, $urandom, a, b, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
